// File: rtl/sha_ctrl_pkg.sv
// Shared types and constants for the SHA block controller.
package sha_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRound  = 2'b01,
    StUpdate = 2'b10,
    StOutput = 2'b11
  } ctrl_state_e;

  localparam int unsigned ROUNDS_SHA256 = 64;
  localparam int unsigned ROUNDS_SHA1   = 80;

endpackage

// File: rtl/sha_round_counter.sv
// Round index counter: counts 0..ROUNDS-1 and flags the final round.
module sha_round_counter #(
  parameter int unsigned ROUNDS = 64,
  localparam int unsigned RND_W = $clog2(ROUNDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [RND_W-1:0] idx_o,
  output logic             terminal_o
);

  localparam logic [RND_W-1:0] LastIdx = RND_W'(ROUNDS - 1);

  logic [RND_W-1:0] idx_q, idx_d;

  // Saturates at the last round; only clear returns it to zero.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (enable_i && (idx_q != LastIdx)) begin
      idx_d = idx_q + RND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o      = idx_q;
  assign terminal_o = (idx_q == LastIdx);

endmodule

// File: rtl/sha_block_ctrl.sv
// Block sequencing FSM for an iterative SHA datapath: block intake, rounds,
// digest accumulate and digest handoff, with abort and chain-error tracking.
module sha_block_ctrl
  import sha_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_SHA256,
  localparam int unsigned RND_W = $clog2(ROUNDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             block_valid_i,
  input  logic             block_first_i,
  input  logic             block_last_i,
  output logic             block_ready_o,
  input  logic             abort_i,
  input  logic             err_clr_i,
  output logic             load_iv_o,
  output logic             round_en_o,
  output logic [RND_W-1:0] round_idx_o,
  output logic             digest_update_o,
  output logic             digest_valid_o,
  input  logic             digest_ready_i,
  output logic             busy_o,
  output logic             chain_active_o,
  output logic             err_seq_o
);

  ctrl_state_e state_q, state_d;
  logic        last_q, last_d;
  logic        chain_q, chain_d;
  logic        err_q, err_d;
  logic        accept;
  logic        cnt_clear, cnt_en, cnt_terminal;

  sha_round_counter #(
    .ROUNDS(ROUNDS)
  ) u_round_counter (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_en),
    .idx_o     (round_idx_o),
    .terminal_o(cnt_terminal)
  );

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    chain_d         = chain_q;
    err_d           = err_q;
    load_iv_o       = 1'b0;
    round_en_o      = 1'b0;
    digest_update_o = 1'b0;
    digest_valid_o  = 1'b0;
    cnt_clear       = 1'b0;
    cnt_en          = 1'b0;

    block_ready_o = (state_q == StIdle) && !abort_i;
    accept        = block_ready_o && block_valid_i && !reset;

    if (err_clr_i) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (block_first_i || chain_q) begin
            load_iv_o = block_first_i;
            last_d    = block_last_i;
            cnt_clear = 1'b1;
            state_d   = StRound;
          end else begin
            // Continuation with no chain: swallow the block, flag it.
            err_d = 1'b1;
          end
        end
      end
      StRound: begin
        round_en_o = 1'b1;
        if (cnt_terminal) begin
          cnt_clear = 1'b1;
          state_d   = StUpdate;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StUpdate: begin
        digest_update_o = 1'b1;
        chain_d         = !last_q;
        state_d         = last_q ? StOutput : StIdle;
      end
      StOutput: begin
        digest_valid_o = 1'b1;
        if (digest_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_i) begin
      state_d   = StIdle;
      cnt_clear = 1'b1;
      chain_d   = 1'b0;
      last_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b0;
      chain_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      chain_q <= chain_d;
      err_q   <= err_d;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign chain_active_o = chain_q;
  assign err_seq_o      = err_q;

endmodule

// File: tb/tb_sha_block_ctrl.sv
// Self-checking bench for sha_block_ctrl: directed scenarios plus random traffic
// against a cycles-since-accept reference model.
module tb_sha_block_ctrl;
  import sha_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, block_valid, block_first, block_last, abort, err_clr, digest_ready;

  logic       a_ready, a_load, a_en, a_upd, a_dv, a_busy, a_chain, a_err;
  logic [5:0] a_idx;
  logic       b_ready, b_load, b_en, b_upd, b_dv, b_busy, b_chain, b_err;
  logic [6:0] b_idx;

  sha_block_ctrl #(.ROUNDS(ROUNDS_SHA256)) u_dut64 (
    .clk(clk), .reset(reset), .block_valid_i(block_valid), .block_first_i(block_first),
    .block_last_i(block_last), .block_ready_o(a_ready), .abort_i(abort), .err_clr_i(err_clr),
    .load_iv_o(a_load), .round_en_o(a_en), .round_idx_o(a_idx), .digest_update_o(a_upd),
    .digest_valid_o(a_dv), .digest_ready_i(digest_ready), .busy_o(a_busy),
    .chain_active_o(a_chain), .err_seq_o(a_err)
  );

  sha_block_ctrl #(.ROUNDS(ROUNDS_SHA1)) u_dut80 (
    .clk(clk), .reset(reset), .block_valid_i(block_valid), .block_first_i(block_first),
    .block_last_i(block_last), .block_ready_o(b_ready), .abort_i(abort), .err_clr_i(err_clr),
    .load_iv_o(b_load), .round_en_o(b_en), .round_idx_o(b_idx), .digest_update_o(b_upd),
    .digest_valid_o(b_dv), .digest_ready_i(digest_ready), .busy_o(b_busy),
    .chain_active_o(b_chain), .err_seq_o(b_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: m_t counts cycles since the accepting cycle (-1 = idle).
  bit          sel80;
  int          r_cnt;
  int          m_t;
  bit          m_last, m_chain, m_err;
  logic [15:0] o_v, e_v;

  function automatic logic [15:0] model_exp();
    bit rdy, acc, en;
    int idx;
    rdy = (m_t < 0) && !abort;
    acc = rdy && block_valid && !reset;
    en  = (m_t >= 1) && (m_t <= r_cnt);
    idx = en ? m_t - 1 : 0;
    return {rdy, acc && block_first, en, 8'(idx), m_t == r_cnt + 1, m_t == r_cnt + 2,
            m_t >= 1, m_chain, m_err};
  endfunction

  task automatic model_next();
    bit acc;
    acc = (m_t < 0) && !abort && block_valid && !reset;
    if (reset) begin
      m_t = -1; m_last = 0; m_chain = 0; m_err = 0;
    end else begin
      if (acc && !block_first && !m_chain) m_err = 1;
      else if (err_clr) m_err = 0;
      if (abort) begin
        m_t = -1; m_last = 0; m_chain = 0;
      end else if (acc) begin
        if (block_first || m_chain) begin
          m_t = 1; m_last = block_last;
        end
      end else if (m_t >= 1 && m_t <= r_cnt) begin
        m_t++;
      end else if (m_t == r_cnt + 1) begin
        if (m_last) begin m_t = r_cnt + 2; m_chain = 0; end
        else begin m_t = -1; m_chain = 1; end
      end else if (m_t == r_cnt + 2 && digest_ready) begin
        m_t = -1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    o_v = sel80 ? {b_ready, b_load, b_en, 8'(b_idx), b_upd, b_dv, b_busy, b_chain, b_err}
                : {a_ready, a_load, a_en, 8'(a_idx), a_upd, a_dv, a_busy, a_chain, a_err};
    e_v = model_exp();
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    block_valid = 0; block_first = 0; block_last = 0; abort = 0; err_clr = 0;
    digest_ready = 1;
  endtask

  task automatic select(input bit s);
    sel80 = s;
    r_cnt = s ? 80 : 64;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    select(0);
    idle_inputs();
    reset = 1; block_valid = 1; block_first = 1; block_last = 1;
    m_t = -1; m_last = 0; m_chain = 0; m_err = 0;
    tick();
    sample();
    checks++;
    if (o_v !== e_v) begin errors++; $display("FAIL reset_hold got=%h exp=%h", o_v, e_v); end
    checks++;
    if (a_ready !== 1'b1 || a_load !== 1'b0 || b_ready !== 1'b1 || b_load !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got ready=%b load=%b exp ready=1 load=0", a_ready, a_load);
    end
    tick();
    reset = 0; block_valid = 0;
    sample();
    checks++;
    if (o_v !== 16'h8000) begin errors++; $display("FAIL reset_state got=%h exp=8000", o_v); end
    tick();
  endtask

  task automatic test_single();
    int t_load = -1, n_load = 0, n_en = 0, max_idx = 0;
    int t_upd = -1, n_upd = 0, t_dv = -1, n_dv = 0;
    logic busy67 = 1'b1;
    select(0);
    do_reset();
    for (int c = 0; c < 70; c++) begin
      block_valid = (c == 0); block_first = 1; block_last = 1;
      sample();
      checks++;
      if (o_v !== e_v) begin
        errors++; $display("FAIL single_trace c=%0d got=%h exp=%h", c, o_v, e_v);
      end
      if (a_load) begin n_load++; t_load = c; end
      if (a_en) begin n_en++; if (int'(a_idx) > max_idx) max_idx = int'(a_idx); end
      if (a_upd) begin n_upd++; t_upd = c; end
      if (a_dv) begin n_dv++; t_dv = c; end
      if (c == 67) busy67 = a_busy;
      tick();
    end
    block_valid = 0;
    checks++;
    if (n_load != 1 || t_load != 0) begin
      errors++; $display("FAIL single_load got n=%0d t=%0d exp n=1 t=0", n_load, t_load);
    end
    checks++;
    if (n_en != 64 || max_idx != 63) begin
      errors++; $display("FAIL single_rounds got n=%0d max=%0d exp 64/63", n_en, max_idx);
    end
    checks++;
    if (n_upd != 1 || t_upd != 65) begin
      errors++; $display("FAIL single_update got n=%0d t=%0d exp n=1 t=65", n_upd, t_upd);
    end
    checks++;
    if (n_dv != 1 || t_dv != 66) begin
      errors++; $display("FAIL single_valid got n=%0d t=%0d exp n=1 t=66", n_dv, t_dv);
    end
    checks++;
    if (busy67 !== 1'b0) begin errors++; $display("FAIL single_busy67 got=%b exp=0", busy67); end
  endtask

  task automatic test_chain();
    int blk = 0, n_load = 0, n_upd = 0, n_dv = 0, max_idx = 0, n_chain_idle = 0;
    select(1);
    do_reset();
    for (int c = 0; c < 260; c++) begin
      block_valid = (blk < 3); block_first = (blk == 0); block_last = (blk == 2);
      sample();
      checks++;
      if (o_v !== e_v) begin
        errors++; $display("FAIL chain_trace c=%0d got=%h exp=%h", c, o_v, e_v);
      end
      if (b_load) n_load++;
      if (b_upd) n_upd++;
      if (b_dv) n_dv++;
      if (b_en && int'(b_idx) > max_idx) max_idx = int'(b_idx);
      if (b_chain && !b_busy) n_chain_idle++;
      if (e_v[15] && block_valid) blk++;
      tick();
    end
    block_valid = 0;
    checks++;
    if (n_load != 1 || n_upd != 3 || n_dv != 1) begin
      errors++;
      $display("FAIL chain_pulses got load=%0d upd=%0d dv=%0d exp 1/3/1", n_load, n_upd, n_dv);
    end
    checks++;
    if (max_idx != 79 || n_chain_idle != 2) begin
      errors++;
      $display("FAIL chain_idx got max=%0d chain_idle=%0d exp 79/2", max_idx, n_chain_idle);
    end
  endtask

  task automatic test_backpressure();
    bit got = 0;
    int n_hold = 0;
    select(0);
    do_reset();
    digest_ready = 0;
    block_valid = 1; block_first = 1; block_last = 1;
    sample();
    checks++;
    if (o_v !== e_v) begin errors++; $display("FAIL bp_accept got=%h exp=%h", o_v, e_v); end
    tick();
    for (int c = 0; c < 100 && !got; c++) begin
      sample();
      checks++;
      if (o_v !== e_v) begin errors++; $display("FAIL bp_wait c=%0d got=%h exp=%h", c, o_v, e_v); end
      if (a_dv) got = 1;
      if (!got) tick();
    end
    checks++;
    if (!got) begin errors++; $display("FAIL bp_timeout got dv=0 exp dv=1"); end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        sample();
        checks++;
        if (o_v !== e_v) begin errors++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, o_v, e_v); end
      end
      if (a_dv && a_busy && !a_ready) n_hold++;
      tick();
    end
    checks++;
    if (n_hold != 10) begin errors++; $display("FAIL bp_held got=%0d exp=10", n_hold); end
    digest_ready = 1;
    sample();
    checks++;
    if (o_v !== e_v) begin errors++; $display("FAIL bp_handshake got=%h exp=%h", o_v, e_v); end
    tick();
    sample();
    checks++;
    if (a_load !== 1'b1 || a_ready !== 1'b1) begin
      errors++; $display("FAIL bp_requeue got load=%b ready=%b exp 1/1", a_load, a_ready);
    end
    tick();
    block_valid = 0;
    for (int c = 0; c < 70; c++) begin
      sample();
      checks++;
      if (o_v !== e_v) begin errors++; $display("FAIL bp_drain c=%0d got=%h exp=%h", c, o_v, e_v); end
      tick();
    end
  endtask

  task automatic test_orphan();
    select(0);
    do_reset();
    block_valid = 1; block_first = 0; block_last = 1'($urandom);
    sample();
    checks++;
    if (o_v !== e_v || a_ready !== 1'b1 || a_load !== 1'b0) begin
      errors++; $display("FAIL orphan_accept got=%h exp=%h", o_v, e_v);
    end
    tick();
    block_valid = 0;
    sample();
    checks++;
    if (a_err !== 1'b1 || a_en !== 1'b0 || a_busy !== 1'b0 || o_v !== e_v) begin
      errors++; $display("FAIL orphan_err got err=%b en=%b busy=%b exp 1/0/0", a_err, a_en, a_busy);
    end
    tick();
    err_clr = 1;
    sample();
    tick();
    err_clr = 0;
    sample();
    checks++;
    if (a_err !== 1'b0 || o_v !== e_v) begin
      errors++; $display("FAIL orphan_clr got err=%b exp 0", a_err);
    end
    tick();
  endtask

  task automatic test_abort();
    bit hit = 0;
    select(0);
    do_reset();
    block_valid = 1; block_first = 1; block_last = 0;
    sample();
    tick();
    block_valid = 0;
    for (int c = 0; c < 80 && m_t >= 0; c++) begin
      sample();
      checks++;
      if (o_v !== e_v) begin errors++; $display("FAIL abort_blk1 c=%0d got=%h exp=%h", c, o_v, e_v); end
      tick();
    end
    block_valid = 1; block_first = 0; block_last = 1;
    sample();
    checks++;
    if (o_v !== e_v) begin errors++; $display("FAIL abort_blk2 got=%h exp=%h", o_v, e_v); end
    tick();
    block_valid = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      sample();
      checks++;
      if (o_v !== e_v) begin errors++; $display("FAIL abort_run c=%0d got=%h exp=%h", c, o_v, e_v); end
      if (a_en && a_idx == 6'd30) hit = 1;
      else tick();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_timeout got no idx30 exp idx30"); end
    abort = 1;
    tick();
    abort = 0;
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++;
      if (a_busy || a_idx != 6'd0 || a_chain || a_upd || o_v !== e_v) begin
        errors++; $display("FAIL abort_idle c=%0d got=%h exp=%h", c, o_v, e_v);
      end
      tick();
    end
    block_valid = 1; block_first = 0; block_last = 1;
    sample();
    tick();
    block_valid = 0;
    sample();
    checks++;
    if (a_err !== 1'b1 || a_busy !== 1'b0 || o_v !== e_v) begin
      errors++; $display("FAIL abort_orphan got err=%b busy=%b exp 1/0", a_err, a_busy);
    end
    tick();
  endtask

  task automatic test_reset_output();
    bit got = 0;
    select(0);
    do_reset();
    block_valid = 1; block_first = 0; block_last = 0;
    sample();
    tick();
    block_first = 1; block_last = 1; digest_ready = 0;
    sample();
    tick();
    block_valid = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      sample();
      checks++;
      if (o_v !== e_v) begin errors++; $display("FAIL rstout_run c=%0d got=%h exp=%h", c, o_v, e_v); end
      if (a_dv) got = 1;
      else tick();
    end
    checks++;
    if (!got || a_err !== 1'b1) begin
      errors++; $display("FAIL rstout_setup got dv=%b err=%b exp 1/1", got, a_err);
    end
    reset = 1;
    tick();
    reset = 0;
    sample();
    checks++;
    if (a_dv || a_busy || !a_ready || a_err || o_v !== e_v) begin
      errors++; $display("FAIL rstout_after got=%h exp=8000", o_v);
    end
    tick();
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 2; seg++) begin
      select(seg[0]);
      do_reset();
      for (int c = 0; c < 1800; c++) begin
        reset        = ($urandom_range(0, 399) == 0);
        block_valid  = 1'($urandom);
        block_first  = ($urandom_range(0, 3) == 0);
        block_last   = 1'($urandom);
        abort        = ($urandom_range(0, 63) == 0);
        err_clr      = ($urandom_range(0, 15) == 0);
        digest_ready = 1'($urandom);
        sample();
        checks++;
        if (o_v !== e_v) begin
          errors++; $display("FAIL random s=%0d c=%0d got=%h exp=%h", seg, c, o_v, e_v);
        end
        tick();
      end
    end
    idle_inputs();
    reset = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_backpressure();
    test_orphan();
    test_abort();
    test_reset_output();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha_block_ctrl.md
Name: sha_block_ctrl

Overview:
- Parametrised control FSM for an iterative SHA-family hash datapath (round core plus message schedule).
- Accepts message blocks over a valid/ready handshake and chains multi-block messages.
- Sequences a configurable number of rounds, then pulses the digest-accumulate step.
- Presents the digest under a valid/ready handshake. Adds abort and sequence-error detection.

Parameters:
ROUNDS, 64, rounds per block (64 = SHA-256, 80 = SHA-1/512); legal range 2..255
RND_W, $clog2(ROUNDS), width of round_idx (derived; must not be overridden)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
block_valid  input  1  upstream has a padded block ready
block_first  input  1  qualifies block_valid: first block of a message
block_last  input  1  qualifies block_valid: last block of a message
block_ready  output  1  controller accepts a block this cycle
abort  input  1  synchronous abort of the current message
err_clr  input  1  clears err_seq
load_iv  output  1  one-cycle pulse: datapath loads initial hash values
round_en  output  1  enables the round core and message schedule
round_idx  output  RND_W  current round number (selects K constant)
digest_update  output  1  one-cycle pulse: H += working variables
digest_valid  output  1  digest is valid
digest_ready  input  1  downstream consumes the digest
busy  output  1  state != IDLE
chain_active  output  1  message in progress between blocks
err_seq  output  1  sticky flag: continuation block received with no active chain

Behaviour:
- Reset values: all outputs 0 except block_ready; state = IDLE; round_idx = 0; chain_active = 0; err_seq = 0.
- Reset overrides every other input.
- States: IDLE, ROUND, UPDATE, OUTPUT.
- block_ready = (state == IDLE) && !abort. It is 1 during reset release.
- IDLE, accept on block_valid && block_ready:
  - If block_first = 1: pulse load_iv in the accept cycle, capture last_q = block_last, go to ROUND with round_idx = 0.
  - If block_first = 1 while chain_active = 1: the old chain is dropped and a new chain starts.
  - If block_first = 0 and chain_active = 1: no load_iv, capture last_q, go to ROUND.
  - If block_first = 0 and chain_active = 0: the block is consumed and dropped, err_seq is set, and the FSM stays in IDLE.
- ROUND:
  - round_en = 1.
  - round_idx increments by 1 every cycle from 0 to ROUNDS-1, never wraps inside a block.
  - After the cycle with round_idx = ROUNDS-1, go to UPDATE and reset round_idx to 0.
- UPDATE:
  - Exactly one cycle with digest_update = 1 and round_en = 0.
  - If last_q = 1: go to OUTPUT and clear chain_active.
  - If last_q = 0: go to IDLE and set chain_active.
- OUTPUT:
  - digest_valid = 1 and held until digest_ready = 1; then go to IDLE.
  - digest_ready while digest_valid = 0 is ignored.
- Latency: accept at cycle T -> round_idx 0 at T+1 -> round_idx ROUNDS-1 at T+ROUNDS -> digest_update at T+ROUNDS+1 -> digest_valid at T+ROUNDS+2 (last block only).
- Throughput: ROUNDS+2 cycles per block minimum, since IDLE must be revisited to accept each block.
- abort:
  - Takes effect in any state: the next state is IDLE, round_idx = 0, chain_active = 0, last_q = 0.
  - Pulses already issued in the abort cycle stand; no new load_iv or digest_update is generated.
  - digest_valid drops the next cycle.
  - abort in IDLE blocks acceptance in that cycle.
- err_seq:
  - Cleared by err_clr or reset.
  - err_clr and a same-cycle set: set wins.
  - abort does not clear err_seq.
- block_first and block_last both 1: a single-block message.
- block_first and block_last are sampled only in the accept cycle.

Decomposition:
- Package sha_ctrl_pkg holds:
  - state enum (IDLE=2'b00, ROUND=2'b01, UPDATE=2'b10, OUTPUT=2'b11)
  - ROUNDS_SHA256 = 64 and ROUNDS_SHA1 = 80 constants
- Sub-module sha_round_counter:
  - Parametrised by ROUNDS.
  - Inputs: clear, enable.
  - Outputs: idx, terminal (idx == ROUNDS-1).
- The FSM, flags and handshakes stay in sha_block_ctrl.

Test Plan:
1. Single block, ROUNDS = 64, first = last = 1, digest_ready tied 1 -> load_iv at T; round_en for 64 cycles, round_idx 0..63; digest_update at T+65; digest_valid for one cycle at T+66; busy low at T+67.
2. Three-block message (first; mid; last), ROUNDS = 80 -> load_iv only on block 1; exactly three digest_update pulses; chain_active high between blocks; one digest_valid after block 3; round_idx peaks at 79.
3. Backpressure: digest_ready low for 10 cycles after digest_valid -> digest_valid and busy held 10 cycles; block_ready = 0 throughout; the queued block is accepted the cycle after the digest_ready handshake.
4. Orphan block: block_valid with first = 0 from reset -> block_ready = 1, err_seq = 1 the next cycle, no round_en; err_clr pulse -> err_seq = 0.
5. abort at round_idx = 30 of a chained message -> IDLE the next cycle, round_idx = 0, chain_active = 0, no digest_update; a following block with first = 0 sets err_seq.
6. Reset asserted in OUTPUT with digest_valid = 1 -> the cycle after reset, digest_valid = 0, busy = 0, block_ready = 1, err_seq = 0.
